// File: rtl/tanh_pipe.sv
// tanh_pipe: four-stage streaming tanh / sigmoid unit in signed fixed point.
// A uniform-segment table over magnitude [0, 4.0) is linearly interpolated;
// sigmoid is derived from tanh of the halved argument.
//
// Handshake: a sample transfers on a rising edge when in_valid && in_ready;
// a result transfers when out_valid && out_ready. All four stages advance
// together on adv = !out_valid || out_ready, and in_ready equals adv, so a
// stalled output freezes the whole pipe and holds out_data stable.
module tanh_pipe #(
    parameter int DATA_W   = 16,
    parameter int FRAC_W   = 12,
    parameter int SEG_BITS = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    localparam int ONE   = 1 << FRAC_W;
    localparam int F     = FRAC_W + 2 - SEG_BITS;
    localparam int FR_W  = (F > 0) ? F : 1;
    localparam int EW    = FRAC_W + 1;           // table entries span [0, ONE]
    localparam int NENT  = (1 << SEG_BITS) + 1;
    localparam int TAB_W = NENT * EW;
    localparam int PW    = EW + FR_W + 1;        // product plus rounding carry
    localparam int RSH   = (F > 0) ? F - 1 : 0;

    localparam logic [DATA_W:0]   RANGE_V = (DATA_W+1)'(1) << (FRAC_W + 2);
    localparam logic [EW-1:0]     ONE_M   = EW'(ONE);
    localparam logic [DATA_W-1:0] ONE_D   = DATA_W'(ONE);
    localparam logic [PW-1:0]     RND     = (F > 0) ? (PW'(1) << RSH) : '0;

    // Builds the packed knot table: entry k = round(tanh(4k/2^SEG_BITS) * ONE).
    function automatic logic [TAB_W-1:0] build_tab();
        logic [TAB_W-1:0] tab;
        logic [EW-1:0]    v;
        real              z;
        real              e2;
        real              th;
        int               iv;
        tab = '0;
        for (int k = 0; k < NENT; k++) begin
            z  = 4.0 * real'(k) / real'(NENT - 1);
            e2 = $exp(2.0 * z);
            th = (e2 - 1.0) / (e2 + 1.0);
            iv = $rtoi(th * real'(ONE) + 0.5);
            v  = iv[EW-1:0];
            tab[k*EW +: EW] = v;
        end
        return tab;
    endfunction

    localparam logic [TAB_W-1:0] TAB = build_tab();

    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Stage valid bits
    logic v1, v2, v3, v4;
    assign out_valid = v4;

    // ---------------- S1: argument conditioning ----------------
    logic [DATA_W-1:0] s1_a;
    logic [DATA_W:0]   s1_ext;
    logic [DATA_W:0]   s1_mag;
    logic              s1_neg;
    logic              s1_sat;

    // Halve for sigmoid, then take sign and a DATA_W+1 bit magnitude.
    always_comb begin
        s1_a = in_data;
        if (in_mode) s1_a = $signed(in_data) >>> 1;
        s1_neg = s1_a[DATA_W-1];
        s1_ext = {s1_a[DATA_W-1], s1_a};
        s1_mag = s1_neg ? (~s1_ext + (DATA_W+1)'(1)) : s1_ext;
        s1_sat = (s1_mag >= RANGE_V);
    end

    logic              mode1, neg1, sat1;
    logic [FRAC_W+1:0] mag1;

    // S1 payload register; only the in-range magnitude bits are needed later.
    always_ff @(posedge clk) begin
        if (adv) begin
            mode1 <= in_mode;
            neg1  <= s1_neg;
            sat1  <= s1_sat;
            mag1  <= s1_mag[FRAC_W+1:0];
        end
    end

    // ---------------- S2: table lookup ----------------
    logic [SEG_BITS:0] s2_idx_lo, s2_idx_hi;
    logic [EW-1:0]     s2_y0, s2_y1;
    logic [FR_W-1:0]   s2_fr;

    // Fetch the two knots bracketing the magnitude.
    always_comb begin
        s2_idx_lo = {1'b0, mag1[FRAC_W+1 -: SEG_BITS]};
        s2_idx_hi = s2_idx_lo + (SEG_BITS+1)'(1);
        s2_y0     = TAB[int'(s2_idx_lo) * EW +: EW];
        s2_y1     = TAB[int'(s2_idx_hi) * EW +: EW];
    end

    if (F > 0) begin : g_fr
        assign s2_fr = mag1[FR_W-1:0];
    end else begin : g_nofr
        assign s2_fr = '0;
    end

    logic            mode2, neg2, sat2;
    logic [EW-1:0]   y0_2, y1_2;
    logic [FR_W-1:0] fr2;

    // S2 payload register.
    always_ff @(posedge clk) begin
        if (adv) begin
            mode2 <= mode1;
            neg2  <= neg1;
            sat2  <= sat1;
            y0_2  <= s2_y0;
            y1_2  <= s2_y1;
            fr2   <= s2_fr;
        end
    end

    // ---------------- S3: interpolation ----------------
    logic [EW-1:0] s3_diff;
    logic [PW-1:0] s3_prod;
    logic [EW-1:0] s3_m;

    // Round-to-nearest chord interpolation; the table is monotone so diff >= 0.
    always_comb begin
        s3_diff = y1_2 - y0_2;
        s3_prod = PW'(s3_diff) * PW'(fr2) + RND;
        s3_m    = y0_2 + EW'(s3_prod >> F);
        if (sat2) s3_m = ONE_M;
    end

    logic          mode3, neg3;
    logic [EW-1:0] m3;

    // S3 payload register.
    always_ff @(posedge clk) begin
        if (adv) begin
            mode3 <= mode2;
            neg3  <= neg2;
            m3    <= s3_m;
        end
    end

    // ---------------- S4: sign restore and mode select ----------------
    logic [DATA_W-1:0] s4_tv, s4_t, s4_sum, s4_res;

    // Reapply the sign; sigmoid maps t in [-ONE, ONE] to [0, ONE] with rounding.
    always_comb begin
        s4_tv  = {{(DATA_W-EW){1'b0}}, m3};
        s4_t   = neg3 ? (~s4_tv + DATA_W'(1)) : s4_tv;
        s4_sum = ONE_D + s4_t + DATA_W'(1);
        s4_res = mode3 ? (s4_sum >> 1) : s4_t;
    end

    // Output register; cleared on reset so a flushed pipe shows zero.
    always_ff @(posedge clk) begin
        if (rst) out_data <= '0;
        else if (adv) out_data <= s4_res;
    end

    // Shared valid chain; reset discards every in-flight sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
            v4 <= 1'b0;
        end else if (adv) begin
            v1 <= in_valid;
            v2 <= v1;
            v3 <= v2;
            v4 <= v3;
        end
    end

endmodule

// File: tb/tb_tanh_pipe.sv
// tb_tanh_pipe: directed and model-checked bench for tanh_pipe (Q4.12, 32 segments).
module tb_tanh_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = 16'h0000;
  logic        in_mode = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_lat = 1'b0;

  logic [15:0] exp_q[$];
  int          t_q[$];
  logic [15:0] x_q[$];
  bit          m_q[$];
  int          tab[0:32];

  tanh_pipe #(.DATA_W(16), .FRAC_W(12), .SEG_BITS(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  // clock / cycle counter
  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // comparison helpers
  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, expv);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0b expected %0b", tag, obs, expv);
    end
  endtask

  task automatic chkint(input string tag, input int obs, input int expv);
    checks++;
    assert (obs == expv) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  // reference model
  function automatic real rtanh(input real z);
    real e;
    e = $exp(2.0 * z);
    return 1.0 - 2.0 / (e + 1.0);
  endfunction

  function automatic logic [15:0] model(input logic [15:0] x, input logic m);
    int a, mag, mm, t, r, idx, fr;
    bit neg;
    a = int'($signed(x));
    if (m) a = a >>> 1;
    neg = (a < 0);
    mag = neg ? -a : a;
    if (mag >= 16384) begin
      mm = 4096;
    end else begin
      idx = mag / 512;
      fr  = mag % 512;
      mm  = tab[idx] + (((tab[idx+1] - tab[idx]) * fr + 256) / 512);
    end
    t = neg ? -mm : mm;
    r = m ? ((4096 + t + 1) / 2) : t;
    return 16'(r);
  endfunction

  // driver tasks
  task automatic send(input logic [15:0] x, input logic m, input logic [15:0] e);
    int n;
    in_valid = 1'b1;
    in_data  = x;
    in_mode  = m;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk1("send_accept_timeout", in_ready, 1'b1);
    end else begin
      exp_q.push_back(e);
      t_q.push_back(cyc);
      x_q.push_back(x);
      m_q.push_back(m);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chkint("drain_queue_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // scoreboard / output monitor
  initial begin
    logic [15:0] prev_data;
    logic [15:0] e, x;
    bit          prev_stall, m;
    int          t0;
    real         d;
    prev_stall = 1'b0;
    prev_data  = 16'h0000;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk1("stall_valid_held", out_valid, 1'b1);
          chk16("stall_data_held", out_data, prev_data);
        end
        if (out_valid && !out_ready) chk1("in_ready_low_on_stall", in_ready, 1'b0);
        if (out_valid && out_ready) begin
          chk1("output_was_expected", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            e  = exp_q.pop_front();
            t0 = t_q.pop_front();
            x  = x_q.pop_front();
            m  = m_q.pop_front();
            chk16("result", out_data, e);
            if (chk_lat) chkint("latency", cyc - t0, 4);
            if (!m) begin
              // chord error for 1/8-wide segments peaks near 6 LSB around |x|=0.66
              d = $itor($signed(out_data)) - rtanh($itor($signed(x)) / 4096.0) * 4096.0;
              chk1("tanh_abs_err_le_8lsb", (d <= 8.0) && (d >= -8.0), 1'b1);
            end
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
      end
    end
  end

  // directed sequence
  initial begin
    logic [15:0] rx;
    logic        rm;

    for (int k = 0; k <= 32; k++) tab[k] = $rtoi(rtanh(real'(k) / 8.0) * 4096.0 + 0.5);

    // reset state
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk1("reset_out_valid", out_valid, 1'b0);
    chk16("reset_out_data", out_data, 16'h0000);
    chk1("reset_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;

    // tanh basics, back-to-back, latency 4
    chk_lat = 1'b1;
    send(16'h0000, 1'b0, 16'h0000);
    send(16'h1000, 1'b0, 16'h0C2F);
    send(16'hF000, 1'b0, 16'hF3D1);
    send(16'h0100, 1'b0, 16'h00FF);
    wait_drain();

    // tanh saturation
    send(16'h4000, 1'b0, 16'h1000);
    send(16'h7FFF, 1'b0, 16'h1000);
    send(16'h8000, 1'b0, 16'hF000);
    send(16'hC000, 1'b0, 16'hF000);
    wait_drain();

    // sigmoid; 0x7FFF lands just below 4.0 on the last chord (knots 4092..4093)
    send(16'h0000, 1'b1, 16'h0800);
    send(16'h2000, 1'b1, 16'h0E18);
    send(16'h8000, 1'b1, 16'h0000);
    send(16'h7FFF, 1'b1, 16'h0FFF);
    wait_drain();

    // backpressure: 12 random samples, out_ready low for 6 cycles mid-stream
    chk_lat = 1'b0;
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          rx = 16'($urandom_range(0, 65535));
          rm = 1'($urandom_range(0, 1));
          send(rx, rm, model(rx, rm));
        end
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // reset with three samples in flight
    chk_lat = 1'b1;
    send(16'h0800, 1'b0, model(16'h0800, 1'b0));
    send(16'hF800, 1'b1, model(16'hF800, 1'b1));
    send(16'h1234, 1'b0, model(16'h1234, 1'b0));
    rst = 1'b1;
    exp_q.delete();
    t_q.delete();
    x_q.delete();
    m_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk1("post_reset_out_valid", out_valid, 1'b0);
    chk16("post_reset_out_data", out_data, 16'h0000);
    chk1("post_reset_in_ready", in_ready, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk1("no_flushed_result", out_valid, 1'b0);
    end
    @(posedge clk);
    #1;
    send(16'h1000, 1'b0, 16'h0C2F);
    wait_drain();

    // strided sweep, both modes, against the model
    for (int i = 0; i < 65536; i += 4) send(16'(i), 1'b0, model(16'(i), 1'b0));
    for (int i = 0; i < 65536; i += 4) send(16'(i), 1'b1, model(16'(i), 1'b1));
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
